// File: rtl/calc_seq_alu_if.sv
// Bus between the switch/key decoder (master) and the calculator core (slave).
// The display drivers read a_q, b_q and result from the same bundle.
interface calc_seq_alu_if #(
    parameter int W = 4
);
    logic [W-1:0]   din;
    logic           load_a;
    logic           load_b;
    logic [1:0]     op;
    logic           start;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] result;
    logic           flag;
    logic           busy;
    logic           done;

    modport master (
        output din, load_a, load_b, op, start,
        input  a_q, b_q, result, flag, busy, done
    );

    modport slave (
        input  din, load_a, load_b, op, start,
        output a_q, b_q, result, flag, busy, done
    );
endinterface

// File: rtl/calc_seq_alu.sv
// Sequential calculator core: A/B operand registers, 2W-bit result register.
// add/sub/acc finish in one edge; mul is a W-edge shift-add loop.
// Every output comes straight from a flop.
module calc_seq_alu #(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          reset,
    calc_seq_alu_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state;
    logic [W-1:0]   a_r, b_r;
    logic [2*W-1:0] res_r;
    logic           flag_r, busy_r, done_r;

    // multiply working set: shifted multiplicand, multiplier shift reg, partial product
    logic [2*W-1:0] mcand, prod;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] a_ext, b_ext, prod_next;
    logic [2*W:0]   acc_sum;

    // operand extension, next partial product and accumulate sum with carry
    always_comb begin
        a_ext     = {{W{1'b0}}, a_r};
        b_ext     = {{W{1'b0}}, b_r};
        prod_next = mplier[0] ? prod + mcand : prod;
        acc_sum   = {1'b0, res_r} + {{(W+1){1'b0}}, a_r};
    end

    // control FSM, operand loads and all datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            flag_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // operations read a_r/b_r as they were before this edge,
                    // so a same-edge load only affects later operations
                    if (bus.load_a) a_r <= bus.din;
                    if (bus.load_b) b_r <= bus.din;
                    if (bus.start) begin
                        case (bus.op)
                            2'b00: begin
                                res_r  <= a_ext + b_ext;
                                flag_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                            2'b01: begin
                                res_r  <= a_ext - b_ext;
                                flag_r <= (a_r < b_r);
                                done_r <= 1'b1;
                            end
                            2'b10: begin
                                mcand  <= a_ext;
                                mplier <= b_r;
                                prod   <= '0;
                                cnt    <= '0;
                                state  <= MUL;
                                busy_r <= 1'b1;
                            end
                            default: begin
                                {flag_r, res_r} <= acc_sum;
                                done_r          <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    // one multiplier bit per edge, LSB first; loads/start ignored
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        res_r  <= prod_next;
                        flag_r <= 1'b0;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_q    = a_r;
    assign bus.b_q    = b_r;
    assign bus.result = res_r;
    assign bus.flag   = flag_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_calc_seq_alu.sv
// Self-checking bench for calc_seq_alu (W=4): directed vector table,
// hand-written multi-cycle corner sequences and a randomized run against
// an arithmetic reference model.
module tb_calc_seq_alu;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    calc_seq_alu_if #(.W(W)) bus ();

    calc_seq_alu #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   a;
        int   b;
        int   op;
        int   res;
        int   flag;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int b);
        bus.din    = W'(a);
        bus.load_a = 1'b1;
        tick();
        bus.load_a = 1'b0;
        bus.din    = W'(b);
        bus.load_b = 1'b1;
        tick();
        bus.load_b = 1'b0;
        check("a_q_load", int'(bus.a_q), a);
        check("b_q_load", int'(bus.b_q), b);
    endtask

    // issue one op and wait (bounded) for done; checks latency, busy length,
    // result, flag, and that done lasts a single cycle
    task automatic run_op(input string name, input int op, input int exp_res, input int exp_flag);
        int lat;
        int bcnt;
        bus.op    = 2'(op);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
        check({name, "_done_seen"}, int'(bus.done), 1);
        check({name, "_latency"}, lat, (op == 2) ? W + 1 : 1);
        check({name, "_busy_cycles"}, bcnt, (op == 2) ? W : 0);
        check({name, "_result"}, int'(bus.result), exp_res);
        check({name, "_flag"}, int'(bus.flag), exp_flag);
        tick();
        check({name, "_done_1cyc"}, int'(bus.done), 0);
        check({name, "_busy_low"}, int'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a_q"}, int'(bus.a_q), 0);
        check({name, "_b_q"}, int'(bus.b_q), 0);
        check({name, "_result"}, int'(bus.result), 0);
        check({name, "_flag"}, int'(bus.flag), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int mres;
        int a, b, op, e, f, s, wait_cnt;

        // directed table; acc rows chain on the previous result
        vecs[0] = '{a: 9,  b: 7,  op: 0, res: 8'h10, flag: 0};
        vecs[1] = '{a: 3,  b: 5,  op: 1, res: 8'hFE, flag: 1};
        vecs[2] = '{a: 5,  b: 3,  op: 1, res: 8'h02, flag: 0};
        vecs[3] = '{a: 0,  b: 9,  op: 2, res: 8'h00, flag: 0};
        vecs[4] = '{a: 9,  b: 1,  op: 2, res: 8'h09, flag: 0};
        vecs[5] = '{a: 15, b: 15, op: 2, res: 8'hE1, flag: 0};
        vecs[6] = '{a: 15, b: 15, op: 3, res: 8'hF0, flag: 0};
        vecs[7] = '{a: 8,  b: 15, op: 3, res: 8'hF8, flag: 0};
        vecs[8] = '{a: 9,  b: 15, op: 3, res: 8'h01, flag: 1};
        vecs[9] = '{a: 2,  b: 12, op: 1, res: 8'hF6, flag: 1};

        reset      = 1'b0;
        bus.din    = '0;
        bus.load_a = 1'b0;
        bus.load_b = 1'b0;
        bus.op     = 2'b00;
        bus.start  = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].a, vecs[i].b);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].res, vecs[i].flag);
        end

        // loads and start during a multiply are ignored and not queued
        load(6, 7);
        bus.op    = 2'b10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.din    = 4'd2;
        bus.load_a = 1'b1;
        bus.op     = 2'b00;
        bus.start  = 1'b1;
        tick();
        bus.load_a = 1'b0;
        bus.start  = 1'b0;
        wait_cnt   = 0;
        while (!bus.done && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("midbusy_done", int'(bus.done), 1);
        check("midbusy_result", int'(bus.result), 8'h2A);
        check("midbusy_a_q", int'(bus.a_q), 6);
        tick();
        check("midbusy_no_extra_done", int'(bus.done), 0);
        tick();
        check("midbusy_no_extra_done2", int'(bus.done), 0);
        check("midbusy_result_hold", int'(bus.result), 8'h2A);

        // same-edge load and start: op uses old A, load still lands
        load(4, 4);
        bus.din    = 4'd1;
        bus.load_a = 1'b1;
        bus.op     = 2'b00;
        bus.start  = 1'b1;
        tick();
        bus.load_a = 1'b0;
        bus.start  = 1'b0;
        check("sameedge_done", int'(bus.done), 1);
        check("sameedge_result", int'(bus.result), 8'h08);
        check("sameedge_a_q", int'(bus.a_q), 1);

        // back-to-back single-cycle starts: A=1, B=2 -> add 3, then acc 4
        load(1, 2);
        bus.op    = 2'b00;
        bus.start = 1'b1;
        tick();
        check("b2b_done1", int'(bus.done), 1);
        check("b2b_result1", int'(bus.result), 3);
        bus.op = 2'b11;
        tick();
        bus.start = 1'b0;
        check("b2b_done2", int'(bus.done), 1);
        check("b2b_result2", int'(bus.result), 4);
        check("b2b_flag2", int'(bus.flag), 0);
        tick();
        check("b2b_done_low", int'(bus.done), 0);

        // reset in the second busy cycle abandons the multiply
        load(13, 11);
        bus.op    = 2'b10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rstmul_busy", int'(bus.busy), 1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero("rstmul");
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("rstmul_no_done", int'(bus.done), 0);
        end
        check("rstmul_result_stays", int'(bus.result), 0);
        load(2, 3);
        run_op("post_reset_add", 0, 5, 0);

        // randomized ops against the arithmetic model
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mres = 0;
        for (int i = 0; i < 150; i++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin e = a + b; f = 0; end
                1: begin e = (a - b) & 8'hFF; f = (a < b) ? 1 : 0; end
                2: begin e = a * b; f = 0; end
                default: begin
                    s = mres + a;
                    e = s & 8'hFF;
                    f = (s > 255) ? 1 : 0;
                end
            endcase
            mres = e;
            load(a, b);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, e, f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
- Parametrised sequential calculator core: two operand registers (A, B) loaded from a shared data bus, and a 2W-bit result register.
- Supports add, subtract, iterative shift-add multiply and accumulate, with a start/busy/done handshake.
- Sits between board switch/key decoding and the seven-segment display drivers; the display logic reads the a_q, b_q and result outputs.

Parameters:
- W, 4, operand width in bits; result width is 2*W (W >= 2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- din  input  W  operand data bus
- load_a  input  1  load din into A (ignored while busy)
- load_b  input  1  load din into B (ignored while busy)
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 acc
- start  input  1  begin operation op (sampled only in IDLE)
- a_q  output  W  current A register
- b_q  output  W  current B register
- result  output  2W  result register
- flag  output  1  status of last completed operation
- busy  output  1  high while in MUL state
- done  output  1  one-cycle pulse when result/flag update

Behaviour:
- Reset (reset==0 at a posedge clk): a_q=0, b_q=0, result=0, flag=0, busy=0, done=0, state=IDLE; all internal counters and working registers cleared. Reset overrides all other inputs, including an in-progress multiply, which is abandoned.
- States: IDLE, MUL. busy is 1 exactly when state==MUL (registered).
- Loads in IDLE: load_a -> A<=din; load_b -> B<=din. Both asserted -> both load din.
- Loads while busy are ignored.
- Start in IDLE at edge k always uses A/B values from before edge k, even if loads occur at the same edge; the loads still take effect.
- add (00), single cycle: at edge k, result<=zero-ext(A)+zero-ext(B); flag<=0; done<=1.
- sub (01), single cycle: at edge k, result<=(zero-ext(A)-zero-ext(B)) mod 2^(2W); flag<=(A<B); done<=1.
- acc (11), single cycle: at edge k, result<=(result+zero-ext(A)) mod 2^(2W); flag<=carry out of bit 2W-1; done<=1.
- mul (10), multi-cycle:
  - Edge k: copy A (multiplicand, 2W working reg) and B (multiplier shift reg); clear the partial product and bit counter; state<=MUL.
  - Edges k+1..k+W: one multiplier bit per edge, LSB first. When the bit is 1, add the shifted multiplicand to the partial product; then shift.
  - At edge k+W: result<=final product; flag<=0; done<=1; state<=IDLE.
  - busy is high in cycles k+1..k+W (W cycles). done is high in cycle k+W+1.
- done: high for exactly one cycle after an updating edge, otherwise 0. Back-to-back single-cycle starts give consecutive done pulses.
- start while busy: ignored; it is neither queued nor able to corrupt the operation.
- result and flag hold their values between operations. A/B changes never alter result without a start.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- W=4, reset, load A=9, B=7, start add -> result=0x10, flag=0, done high exactly 1 cycle after start edge, busy never high.
- A=3, B=5, start sub -> result=0xFE, flag=1. Then A=5, B=3 -> result=0x02, flag=0.
- A=15, B=15, start mul -> busy high 4 cycles, done in cycle 5 after start edge, result=0xE1, flag=0. Also cover A=0, B=9 -> 0x00 and A=9, B=1 -> 0x09.
- result=0xF8 (via A=15, B=15 -> 0xE1, then acc with A=15 -> 0xF0, then A=8 acc -> 0xF8), then A=9 acc -> result=0x01, flag=1.
- During mul (A=6, B=7): assert load_a with din=2 and start with op=add mid-busy -> ignored; result=0x2A, a_q=6 afterwards. Same-edge load_a (din=1) + start add with A=4, B=4 -> result=0x08, a_q=1.
- Assert reset at cycle 2 of a mul -> next cycle all outputs 0, state IDLE; a new add after reset works normally.
